// File: rtl/max_scan_ctrl.sv
// rtl/max_scan_ctrl.sv - sequencer that loads the max-finder operand bank from memory and captures the result
module max_scan_ctrl #(
    parameter int N_ELEM     = 25,
    parameter int SETTLE_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic [31:0] mem_rdata,
    output logic        op_we,
    output logic [4:0]  op_sel,
    output logic [31:0] op_data,
    input  logic [31:0] mayor_in,
    output logic [31:0] num_mayor,
    output logic        busy,
    output logic        done
);

    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [4:0]    LAST_IDX   = 5'(N_ELEM - 1);
    localparam logic [CW-1:0] LAST_SETTLE = CW'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_DATA,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [4:0]  idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] op_data_q, op_data_d;
    logic [31:0] num_mayor_q, num_mayor_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            op_data_q   <= '0;
            num_mayor_q <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            op_data_q   <= op_data_d;
            num_mayor_q <= num_mayor_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        op_data_d   = op_data_q;
        num_mayor_d = num_mayor_q;
        mem_req     = 1'b0;
        op_we       = 1'b0;
        done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = {base_addr[31:2], 2'b00};
                    idx_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // address is a pure function of latched base and index, so it stays put across stalls
                mem_req = 1'b1;
                if (mem_gnt) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                op_we     = 1'b1;
                op_data_d = mem_rdata;
                if (idx_q == LAST_IDX) begin
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end else begin
                    idx_d   = idx_q + 5'd1;
                    state_d = S_REQ;
                end
            end
            S_SETTLE: begin
                if (cnt_q == LAST_SETTLE) begin
                    num_mayor_d = mayor_in;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_addr  = base_q + {25'd0, idx_q, 2'b00};
    assign op_sel    = idx_q;
    assign op_data   = (state_q == S_DATA) ? mem_rdata : op_data_q;
    assign num_mayor = num_mayor_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_max_scan_ctrl.sv
// tb/tb_max_scan_ctrl.sv - randomized self-checking bench for max_scan_ctrl
module tb_max_scan_ctrl;
    localparam int N = 25;
    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic [31:0] mem_rdata;
    logic        op_we;
    logic [4:0]  op_sel;
    logic [31:0] op_data;
    logic [31:0] mayor_in;
    logic [31:0] num_mayor;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    max_scan_ctrl #(.N_ELEM(N), .SETTLE_CYC(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
        .op_we(op_we), .op_sel(op_sel), .op_data(op_data),
        .mayor_in(mayor_in), .num_mayor(num_mayor), .busy(busy), .done(done)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] bank [N];

    int          obs_done_cyc;
    int          obs_done_cnt;
    int          obs_unstable;
    int          obs_tail_busy;
    bit          obs_busy1;
    bit          obs_timeout;
    logic [31:0] obs_max;
    logic [31:0] obs_pre_max;
    logic [31:0] obs_addr [$];
    int          obs_sel [$];
    logic [31:0] obs_data [$];

    function automatic logic [31:0] elem_addr(input logic [31:0] base, input int k);
        logic [31:0] aligned;
        aligned = base & 32'hFFFF_FFFC;
        return aligned + 32'(4 * k);
    endfunction

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return 32'hDEAD_BEEF;
    endfunction

    // Datapath stand-in: unsigned maximum over whatever the bank currently holds
    function automatic logic [31:0] bank_max();
        logic [31:0] m;
        m = 32'd0;
        for (int j = 0; j < N; j++) if (bank[j] > m) m = bank[j];
        return m;
    endfunction

    function automatic logic [31:0] model_max(input logic [31:0] base);
        logic [31:0] m;
        m = 32'd0;
        for (int k = 0; k < N; k++) if (rd(elem_addr(base, k)) > m) m = rd(elem_addr(base, k));
        return m;
    endfunction

    // Drives one scan cycle by cycle and records what the DUT did; k counts cycles from the start edge
    task automatic run_scan(input logic [31:0] base, input int stall, input bit noise);
        int k;
        int wait_c;
        bit fired;
        bit pending;
        logic [31:0] fired_addr;
        logic [31:0] last_addr;
        obs_addr.delete(); obs_sel.delete(); obs_data.delete();
        obs_done_cyc = -1; obs_done_cnt = 0; obs_unstable = 0; obs_tail_busy = 0;
        obs_timeout = 0; obs_max = 32'hx; obs_pre_max = num_mayor; obs_busy1 = 0;
        @(negedge clk);
        base_addr = base;
        start = 1'b1;
        mem_gnt = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        base_addr = $urandom;
        k = 1; wait_c = 0; fired = 0; pending = 0; fired_addr = '0; last_addr = '0;
        while (1) begin
            mem_rdata = fired ? rd(fired_addr) : $urandom;
            #1;
            fired = 0;
            if (k == 1) begin
                obs_busy1 = busy;
                obs_pre_max = num_mayor;
            end
            if (mem_req) begin
                if (pending && mem_addr !== last_addr) obs_unstable++;
                mem_gnt = (wait_c >= stall);
                if (mem_gnt) begin
                    fired = 1; fired_addr = mem_addr; obs_addr.push_back(mem_addr);
                    wait_c = 0; pending = 0;
                end else begin
                    wait_c++; pending = 1; last_addr = mem_addr;
                end
            end else begin
                mem_gnt = 1'($urandom_range(0, 1));
                pending = 0;
            end
            if (op_we) begin
                obs_sel.push_back(int'(op_sel));
                obs_data.push_back(op_data);
                if (int'(op_sel) < N) bank[op_sel] = op_data;
                mayor_in = bank_max();
            end
            if (done) begin
                obs_done_cnt++;
                if (obs_done_cnt == 1) begin
                    obs_done_cyc = k;
                    obs_max = num_mayor;
                end
            end
            if (obs_done_cnt > 0 && k > obs_done_cyc && busy) obs_tail_busy++;
            if (noise && busy) begin
                start = done ? 1'b1 : 1'($urandom_range(0, 1));
                base_addr = $urandom;
            end else begin
                start = 1'b0;
            end
            if (obs_done_cnt > 0 && k >= obs_done_cyc + 4) break;
            if (k >= 600) begin
                obs_timeout = 1;
                break;
            end
            @(posedge clk);
            #1;
            k++;
        end
        start = 1'b0;
    endtask

    task automatic fill_mem(input logic [31:0] base, input int mode);
        mem_model.delete();
        for (int k = 0; k < N; k++) begin
            case (mode)
                0: mem_model[elem_addr(base, k)] = 32'(k + 1);
                1: mem_model[elem_addr(base, k)] = (k == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
                2: mem_model[elem_addr(base, k)] = 32'hFFFF_FFFF;
                default: mem_model[elem_addr(base, k)] = $urandom;
            endcase
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; mem_gnt = 1'b0; mem_rdata = '0; mayor_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if ({mem_req, mem_addr, op_we, op_sel, op_data, num_mayor, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b addr=%h we=%b sel=%0d data=%h max=%h busy=%b done=%b, expected all zero",
                     mem_req, mem_addr, op_we, op_sel, op_data, num_mayor, busy, done);
        end
    endtask

    task automatic test_ascending;
        logic [31:0] base;
        base = 32'h0000_0100;
        fill_mem(base, 0);
        run_scan(base, 0, 0);
        checks++;
        if (obs_timeout || obs_done_cyc != 2 * N + S + 1) begin
            errors++; $display("FAIL asc_done_cycle: got %0d expected %0d", obs_done_cyc, 2 * N + S + 1);
        end
        checks++;
        if (obs_max !== 32'd25) begin
            errors++; $display("FAIL asc_max: got %h expected %h", obs_max, 32'd25);
        end
        checks++;
        if (obs_addr.size() != N || obs_sel.size() != N) begin
            errors++; $display("FAIL asc_counts: addrs %0d writes %0d expected %0d", obs_addr.size(), obs_sel.size(), N);
        end else begin
            for (int k = 0; k < N; k++) begin
                checks++;
                if (obs_addr[k] !== 32'h100 + 32'(4 * k) || obs_sel[k] != k || obs_data[k] !== 32'(k + 1)) begin
                    errors++;
                    $display("FAIL asc_elem%0d: addr %h sel %0d data %h expected %h %0d %h",
                             k, obs_addr[k], obs_sel[k], obs_data[k], 32'h100 + 32'(4 * k), k, 32'(k + 1));
                end
            end
        end
        checks++;
        if (!obs_busy1 || obs_tail_busy != 0 || obs_done_cnt != 1) begin
            errors++; $display("FAIL asc_busy_done: busy1=%b tail_busy=%0d dones=%0d expected 1 0 1",
                               obs_busy1, obs_tail_busy, obs_done_cnt);
        end
    endtask

    task automatic test_max_first;
        logic [31:0] base;
        base = 32'h0000_4000;
        fill_mem(base, 1);
        run_scan(base, 0, 0);
        checks++;
        if (obs_max !== 32'h8000_0000) begin
            errors++; $display("FAIL maxfirst_max: got %h expected %h", obs_max, 32'h8000_0000);
        end
        checks++;
        if (obs_data.size() != N || obs_data[0] !== 32'h8000_0000) begin
            errors++; $display("FAIL maxfirst_word0: writes %0d", obs_data.size());
        end
    endtask

    task automatic test_grant_stall;
        logic [31:0] base;
        base = 32'h0001_0000;
        fill_mem(base, 2);
        run_scan(base, 3, 0);
        checks++;
        if (obs_unstable != 0) begin
            errors++; $display("FAIL stall_addr_stable: %0d changes, expected 0", obs_unstable);
        end
        checks++;
        if (obs_max !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL stall_max: got %h expected %h", obs_max, 32'hFFFF_FFFF);
        end
        checks++;
        if (obs_done_cyc != 2 * N + S + 1 + 3 * N) begin
            errors++; $display("FAIL stall_done_cycle: got %0d expected %0d", obs_done_cyc, 2 * N + S + 1 + 3 * N);
        end
    endtask

    task automatic test_addr_wrap;
        logic [31:0] base;
        base = 32'hFFFF_FFF3;
        fill_mem(base, 3);
        run_scan(base, 1, 0);
        checks++;
        if (obs_addr.size() < 5 || obs_addr[0] !== 32'hFFFF_FFF0 || obs_addr[4] !== 32'h0000_0000) begin
            errors++; $display("FAIL wrap_addr: got %0d addrs, first %h, elem4 %h expected fffffff0 00000000",
                               obs_addr.size(), obs_addr.size() > 0 ? obs_addr[0] : 32'hx,
                               obs_addr.size() > 4 ? obs_addr[4] : 32'hx);
        end
        checks++;
        if (obs_max !== model_max(base)) begin
            errors++; $display("FAIL wrap_max: got %h expected %h", obs_max, model_max(base));
        end
    endtask

    task automatic test_reset_mid_scan;
        int k;
        int dones;
        int busies;
        logic [31:0] base;
        base = 32'h0000_0200;
        @(negedge clk);
        base_addr = base; start = 1'b1; mem_gnt = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (!(op_we && op_sel == 5'd10) && k < 200) begin
            @(posedge clk);
            #1;
            mem_rdata = $urandom;
            #1;
            k++;
        end
        checks++;
        if (k >= 200) begin
            errors++; $display("FAIL midreset_reach: element 10 write not seen within %0d cycles", k);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        #1;
        checks++;
        if ({mem_req, mem_addr, op_we, op_sel, op_data, num_mayor, busy, done} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: req=%b addr=%h we=%b sel=%0d data=%h max=%h busy=%b done=%b, expected all zero",
                     mem_req, mem_addr, op_we, op_sel, op_data, num_mayor, busy, done);
        end
        dones = 0; busies = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            mem_rdata = $urandom;
            if (done) dones++;
            if (busy) busies++;
        end
        checks++;
        if (dones != 0 || busies != 0) begin
            errors++; $display("FAIL midreset_quiet: dones %0d busy cycles %0d expected 0 0", dones, busies);
        end
        fill_mem(base, 3);
        run_scan(base, 0, 0);
        checks++;
        if (obs_done_cnt != 1 || obs_max !== model_max(base)) begin
            errors++; $display("FAIL midreset_rescan: dones %0d max %h expected 1 %h", obs_done_cnt, obs_max, model_max(base));
        end
    endtask

    task automatic test_start_ignored;
        logic [31:0] base;
        logic [31:0] prev;
        prev = num_mayor;
        base = 32'h0000_8000;
        fill_mem(base, 3);
        run_scan(base, 1, 1);
        checks++;
        if (obs_pre_max !== prev) begin
            errors++; $display("FAIL noise_hold: num_mayor %h before capture expected %h", obs_pre_max, prev);
        end
        checks++;
        if (obs_done_cnt != 1 || obs_tail_busy != 0) begin
            errors++; $display("FAIL noise_single_done: dones %0d tail busy %0d expected 1 0", obs_done_cnt, obs_tail_busy);
        end
        checks++;
        if (obs_max !== model_max(base)) begin
            errors++; $display("FAIL noise_max: got %h expected %h", obs_max, model_max(base));
        end
        checks++;
        if (obs_addr.size() != N || obs_addr[N-1] !== elem_addr(base, N - 1)) begin
            errors++; $display("FAIL noise_base_latched: %0d addrs", obs_addr.size());
        end
    endtask

    task automatic test_random;
        logic [31:0] base;
        int stall;
        for (int r = 0; r < 3; r++) begin
            base = $urandom;
            stall = $urandom_range(0, 2);
            fill_mem(base, 3);
            run_scan(base, stall, 0);
            checks++;
            if (obs_max !== model_max(base)) begin
                errors++; $display("FAIL rand%0d_max: got %h expected %h", r, obs_max, model_max(base));
            end
            checks++;
            if (obs_done_cyc != 2 * N + S + 1 + stall * N) begin
                errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", r, obs_done_cyc, 2 * N + S + 1 + stall * N);
            end
            checks++;
            if (obs_data.size() != N) begin
                errors++; $display("FAIL rand%0d_writes: got %0d expected %0d", r, obs_data.size(), N);
            end else begin
                for (int k = 0; k < N; k++) begin
                    checks++;
                    if (obs_data[k] !== rd(elem_addr(base, k)) || obs_sel[k] != k) begin
                        errors++; $display("FAIL rand%0d_elem%0d: sel %0d data %h expected %0d %h",
                                           r, k, obs_sel[k], obs_data[k], k, rd(elem_addr(base, k)));
                    end
                end
            end
        end
    endtask

    initial begin
        for (int j = 0; j < N; j++) bank[j] = 32'd0;
        test_reset();
        test_ascending();
        test_max_first();
        test_grant_stall();
        test_addr_wrap();
        test_reset_mid_scan();
        test_start_ignored();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/max_scan_ctrl.md
# max_scan_ctrl

Sequencer for the 25-input, 32-bit maximum-finder datapath (the combinational comparator chain producing the largest unsigned operand). On a start command it fetches N consecutive words from data memory through a request/grant read port and writes each one into the comparator's operand register bank. It then waits a fixed settle interval for the comparator chain and captures the comparator output as the result, signalling completion with a one-cycle done pulse.

## Interface
- N_ELEM, 25: number of operands fetched; also the depth of the operand bank.
- SETTLE_CYC, 2: cycles to wait after the last operand write before the comparator output is captured; must be ≥1.
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin a scan; sampled only in IDLE.
- base_addr  in  32  byte address of operand 0; sampled with start.
- mem_req  out  1  read request.
- mem_addr  out  32  word-aligned read address.
- mem_gnt  in  1  request accepted this cycle.
- mem_rdata  in  32  read data, valid the cycle after the cycle in which mem_req&&mem_gnt.
- op_we  out  1  operand bank write strobe.
- op_sel  out  5  operand index being written, 0..N_ELEM-1.
- op_data  out  32  operand value.
- mayor_in  in  32  comparator chain output (unsigned max of the bank).
- num_mayor  out  32  captured maximum; holds until the next capture.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when num_mayor is updated.

## Operation
- States: IDLE, REQ, DATA, SETTLE, DONE.
- IDLE: if start=1, latch base_addr with bits [1:0] forced to 00, clear index i=0, go to REQ. Otherwise stay.
- REQ: mem_req=1, mem_addr=base+4*i (mod 2^32, wraps silently). mem_req and mem_addr are held stable until mem_gnt=1, then the block goes to DATA. Only one request is ever outstanding.
- DATA: op_we=1, op_sel=i, op_data=mem_rdata, all in this cycle. If i==N_ELEM-1, clear the settle counter and go to SETTLE. Otherwise increment i and go to REQ.
- SETTLE: count SETTLE_CYC cycles, then go to DONE.
- DONE: num_mayor<=mayor_in on entry. done=1 for exactly this one cycle, then go to IDLE.
- start is ignored in every state except IDLE, including DONE. base_addr is not re-sampled while busy.
- Outputs mem_req and op_we are 0 in every state not listed above. mem_addr, op_sel and op_data may hold their last values when their strobe is low.
- Reset values, applied when rst_n=0 at an edge, in any state including mid-scan: state IDLE, mem_req 0, mem_addr 0, op_we 0, op_sel 0, op_data 0, num_mayor 0, busy 0, done 0, i 0.
- Reset mid-scan abandons the scan. Any in-flight read data returned after reset is ignored. The operand bank is not cleared by this block.
- The comparison is unsigned and performed entirely in the datapath. This block never alters data values.

## Timing
- Cycle 0 is the edge where start is sampled in IDLE.
- With mem_gnt tied to 1: element i is requested in cycle 1+2i and written in cycle 2+2i. The last write falls in cycle 2·N_ELEM (50). SETTLE occupies cycles 51..50+SETTLE_CYC. done=1 and the new num_mayor are visible in cycle 51+SETTLE_CYC (53 at defaults).
- Each cycle of mem_gnt=0 in REQ adds exactly one cycle of latency. Total latency is 2·N_ELEM+SETTLE_CYC+1+(stall cycles).
- busy rises in cycle 1 and falls in the cycle after done. A new start can be accepted at the earliest in the cycle after done.

## Test plan
- Ascending data: memory words 1..25 at base 0x100, mem_gnt=1 -> addresses 0x100..0x160 step 4; op_sel 0..24 in order; num_mayor=25; done in cycle 53.
- Max first, plus unsigned check: word0=0x8000_0000, others 0x7FFF_FFFF -> num_mayor=0x8000_0000.
- Grant stalls: mem_gnt low for 3 cycles on every request, all words 0xFFFF_FFFF -> mem_addr held stable during each stall; num_mayor=0xFFFF_FFFF; done in cycle 53+75=128.
- Address wrap and alignment: base_addr=0xFFFF_FFF3 -> first address 0xFFFF_FFF0; element 4 at 0x0000_0000.
- Reset mid-scan: rst_n=0 for one edge while writing element 10 -> all outputs at reset values next cycle; no done pulse; a new start then completes normally with a fresh num_mayor.
- start pulsed during busy and in the DONE cycle -> ignored; exactly one done per accepted start; num_mayor unchanged until the next capture.
